// File: rtl/ir_pkg.sv
// ir_pkg
// Shared definitions for the NEC infrared transmitter:
//   - ir_state_e   : transmitter FSM states
//   - U_*          : length of each state in NEC time units
//   - DEF_*_CLKS   : default timing for a 50 MHz clock
//   - state_units(): units a state lasts, given the bit currently being sent
//   - is_mark()    : states in which the emitter is driven
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        REP_SPACE  = 3'd3,
        BIT_MARK   = 3'd4,
        BIT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6,
        GAP        = 3'd7
    } ir_state_e;

    localparam int unsigned DEF_UNIT_CLKS    = 28125; // 562.5 us at 50 MHz
    localparam int unsigned DEF_CARRIER_CLKS = 1316;  // 38 kHz at 50 MHz

    localparam logic [6:0] U_LEAD_MARK  = 7'd16;
    localparam logic [6:0] U_LEAD_SPACE = 7'd8;
    localparam logic [6:0] U_REP_SPACE  = 7'd4;
    localparam logic [6:0] U_ONE_SPACE  = 7'd3;
    localparam logic [6:0] U_SHORT      = 7'd1;  // bit mark, zero space, stop mark
    localparam logic [6:0] U_GAP        = 7'd72;

    function automatic logic [6:0] state_units(input ir_state_e st, input logic bit_val);
        logic [6:0] u;
        case (st)
            LEAD_MARK:  u = U_LEAD_MARK;
            LEAD_SPACE: u = U_LEAD_SPACE;
            REP_SPACE:  u = U_REP_SPACE;
            BIT_SPACE:  u = bit_val ? U_ONE_SPACE : U_SHORT;
            GAP:        u = U_GAP;
            default:    u = U_SHORT;
        endcase
        return u;
    endfunction

    function automatic logic is_mark(input ir_state_e st);
        return (st == LEAD_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_unit_tick.sv
// ir_unit_tick
// Restartable prescaler: tick_o is high for one cycle every UNIT_CLKS cycles,
// counted from the cycle after restart_i was last high.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   restart_i in  clear the count (first tick comes UNIT_CLKS cycles later)
//   tick_o    out one-cycle pulse at the end of each unit
module ir_unit_tick
    import ir_pkg::*;
#(
    parameter int unsigned UNIT_CLKS = DEF_UNIT_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ir_transmit.sv
// ir_transmit
// NEC infrared frame transmitter (full frame or repeat frame).
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (aborts any frame, no done)
//   start_i   in   request a full frame with data_i
//   repeat_i  in   request a repeat frame
//   data_i    in   [15:0] custom code, [23:16] key, [31:24] inverted key
//   busy_o    out  frame in progress
//   done_o    out  one-cycle pulse after the gap of a frame
//   ir_tx_o   out  emitter drive, 1 = on
//   state_o   out  current FSM state (ir_state_e encoding), for observation
// Build option: define IR_CARRIER_EN to modulate marks with a 38 kHz carrier;
// otherwise marks are a constant 1.
//
// Handshake: start_i/repeat_i are plain level requests sampled only while the
// FSM is IDLE (including the cycle done_o is high); start wins over repeat,
// requests seen while busy are dropped, and data_i is captured on the accepting
// edge only.
module ir_transmit
    import ir_pkg::*;
#(
    parameter int unsigned UNIT_CLKS    = DEF_UNIT_CLKS,
    parameter int unsigned CARRIER_CLKS = DEF_CARRIER_CLKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        repeat_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ir_tx_o,
    output logic [2:0]  state_o
);

    ir_state_e   state_q, state_d;
    logic [31:0] data_q;
    logic        rep_q;
    logic [5:0]  bit_idx_q;
    logic [6:0]  unit_q;
    logic        busy_q, done_q, tx_q;

    logic tick, restart, last_unit, accept, adv, cur_bit, tx_d;

    ir_unit_tick #(.UNIT_CLKS(UNIT_CLKS)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_comb begin
        cur_bit   = data_q[bit_idx_q[4:0]];
        last_unit = (unit_q == state_units(state_q, cur_bit) - 7'd1);
        accept    = (state_q == IDLE) && (start_i || repeat_i);
        adv       = (state_q != IDLE) && tick && last_unit;
        state_d   = state_q;
        if (accept) begin
            state_d = LEAD_MARK;
        end else if (adv) begin
            case (state_q)
                LEAD_MARK:  state_d = rep_q ? REP_SPACE : LEAD_SPACE;
                LEAD_SPACE: state_d = BIT_MARK;
                REP_SPACE:  state_d = STOP_MARK;
                BIT_MARK:   state_d = BIT_SPACE;
                BIT_SPACE:  state_d = (bit_idx_q == 6'd31) ? STOP_MARK : BIT_MARK;
                STOP_MARK:  state_d = GAP;
                default:    state_d = IDLE;
            endcase
        end
        // Every transition enters a different state, so a state change is
        // exactly a state entry; holding the prescaler in IDLE keeps it aligned.
        restart = (state_d != state_q) || (state_q == IDLE);
    end

`ifdef IR_CARRIER_EN
    localparam int unsigned PW = (CARRIER_CLKS > 1) ? $clog2(CARRIER_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CARRIER_CLKS - 1);

    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        // Restart the carrier at each mark entry so every mark begins high.
        if (is_mark(state_d) && (state_d != state_q)) phase_d = '0;
        tx_d = is_mark(state_d) && (32'(phase_d) < CARRIER_CLKS / 2);
    end

    always_ff @(posedge clk) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end
`else
    always_comb tx_d = is_mark(state_d);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            rep_q     <= 1'b0;
            bit_idx_q <= '0;
            unit_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= adv && (state_q == GAP);
            tx_q    <= tx_d;
            if (accept) begin
                data_q    <= data_i;
                rep_q     <= ~start_i;
                bit_idx_q <= '0;
            end else if (adv && (state_q == BIT_SPACE)) begin
                bit_idx_q <= bit_idx_q + 6'd1;
            end
            if (state_d != state_q) unit_q <= '0;
            else if (tick)          unit_q <= unit_q + 7'd1;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ir_tx_o = tx_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ir_transmit.sv
// tb_ir_transmit
// Self-checking bench for ir_transmit with UNIT_CLKS=4, CARRIER_CLKS=4.
// A waveform-level model expands each accepted request into the per-cycle
// {ir_tx, busy, done} sequence the frame must produce; a compare process
// checks the DUT against it every cycle. Directed frames pin the model with
// hand-computed run lengths. Honours IR_CARRIER_EN like the design.
module tb_ir_transmit;

  localparam int UNIT = 4;
  localparam int CAR  = 4;

  // clock / reset
  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        start_i  = 1'b0;
  logic        repeat_i = 1'b0;
  logic [31:0] data_i   = '0;
  logic        busy_o, done_o, ir_tx_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  ir_transmit #(.UNIT_CLKS(UNIT), .CARRIER_CLKS(CAR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .repeat_i (repeat_i),
    .data_i   (data_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ir_tx_o  (ir_tx_o),
    .state_o  (state_o)
  );

  int tests      = 0;
  int errors     = 0;
  int done_total = 0;
  int fail_lines = 0;

  // scoreboard: expected {ir_tx, busy, done} per cycle
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur  = 3'b000;
  logic       model_ok = 1'b0;

  int wave[$];
  int runs[$];
  int cap_len;
  int cap_done;

  task automatic push_seg(input bit mark, input int units);
    for (int i = 0; i < units * UNIT; i++) begin
      logic tx;
`ifdef IR_CARRIER_EN
      tx = mark && ((i % CAR) < (CAR / 2));
`else
      tx = mark;
`endif
      exp_q.push_back({tx, 1'b1, 1'b0});
    end
  endtask

  task automatic build_frame(input bit is_rep, input logic [31:0] d);
    push_seg(1'b1, 16);
    if (is_rep) begin
      push_seg(1'b0, 4);
    end else begin
      push_seg(1'b0, 8);
      for (int b = 0; b < 32; b++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, d[b] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
    push_seg(1'b0, 72);
    exp_q.push_back(3'b001);
  endtask

  // model: advances on every rising edge using the inputs the DUT samples
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cur  <= 3'b000;
      model_ok <= 1'b1;
    end else if (exp_q.size() > 0) begin
      exp_cur <= exp_q.pop_front();
    end else if (start_i || repeat_i) begin
      build_frame(!start_i, data_i);
      exp_cur <= exp_q.pop_front();
    end else begin
      exp_cur <= 3'b000;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (model_ok) begin
      tests++;
      if ({ir_tx_o, busy_o, done_o} !== exp_cur) begin
        errors++;
        if (fail_lines < 20) begin
          fail_lines++;
          $display("FAIL cycle_cmp t=%0t tx/busy/done got %b%b%b want %b",
                   $time, ir_tx_o, busy_o, done_o, exp_cur);
        end
      end
    end
    if (done_o === 1'b1) done_total++;
  end

  // driver tasks
  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Presents a request now; it is sampled at the next rising edge.
  task automatic req(input bit s, input bit r, input logic [31:0] d);
    start_i  = s;
    repeat_i = r;
    data_i   = d;
    @(posedge clk);
    #2;
    start_i  = 1'b0;
    repeat_i = 1'b0;
    data_i   = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic capture(input bit s, input bit r, input logic [31:0] d);
    int n  = 0;
    int d0 = done_total;
    wave.delete();
    runs.delete();
    req(s, r, d);
    @(negedge clk);
    check("busy_latency", int'(busy_o), 1);
    while (busy_o && n < 3000) begin
      wave.push_back(int'(ir_tx_o));
      n++;
      @(negedge clk);
    end
    if (busy_o) check("frame_timeout", 1, 0);
    repeat (4) @(negedge clk);
    cap_len  = n;
    cap_done = done_total - d0;
    for (int i = 0; i < wave.size(); i++) begin
      if (i == 0 || wave[i] != wave[i-1]) runs.push_back(1);
      else runs[runs.size()-1] = runs[runs.size()-1] + 1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1);
  end

  initial begin
    int d0;
    logic [31:0] d;
    int mode, act, gap;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_tx", int'(ir_tx_o), 0);

    // full frame E51A00FF: 16 ones, 16 zeros -> 96 + 16*16 + 16*8 + 4 + 288
    capture(1'b1, 1'b0, 32'hE51A00FF);
    check("full_busy_len", cap_len, 772);
    check("full_done", cap_done, 1);
`ifndef IR_CARRIER_EN
    check("full_run_count", runs.size(), 68);
    check("lead_mark", runs[0], 64);
    check("lead_space", runs[1], 32);
    check("bit0_mark", runs[2], 4);
    check("bit0_space", runs[3], 12);
    check("bit8_mark", runs[18], 4);
    check("bit8_space", runs[19], 4);
    check("stop_mark", runs[66], 4);
    check("gap_len", runs[67], 288);
`else
    check("car_lead_c0", wave[0], 1);
    check("car_lead_c1", wave[1], 1);
    check("car_lead_c2", wave[2], 0);
    check("car_lead_c3", wave[3], 0);
    check("car_lead_c4", wave[4], 1);
    check("car_lead_space", wave[64], 0);
    check("car_bit0_mark_start", wave[96], 1);
    check("car_bit0_space", wave[100], 0);
`endif

    // repeat frame: 64 + 16 + 4 + 288
    capture(1'b0, 1'b1, $urandom);
    check("rep_busy_len", cap_len, 372);
    check("rep_done", cap_done, 1);
`ifndef IR_CARRIER_EN
    check("rep_run_count", runs.size(), 4);
    check("rep_lead", runs[0], 64);
    check("rep_space", runs[1], 16);
    check("rep_stop", runs[2], 4);
    check("rep_gap", runs[3], 288);
`endif

    // start and repeat together: start wins; all-zero payload -> 96+256+4+288
    capture(1'b1, 1'b1, 32'h00000000);
    check("both_busy_len", cap_len, 644);
    check("both_done", cap_done, 1);

    // requests during a frame are ignored
    d0 = done_total;
    req(1'b1, 1'b0, 32'h12345678);
    repeat (100) @(posedge clk);
    #2;
    req(1'b1, 1'b0, 32'hFFFFFFFF);
    req(1'b0, 1'b1, 32'h0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("ignored_done", done_total - d0, 1);

    // reset during bit 10 (bit 10 starts 240 cycles after busy rises)
    d0 = done_total;
    req(1'b1, 1'b0, 32'hE51A00FF);
    repeat (242) @(posedge clk);
    #2;
    do_reset();
    @(negedge clk);
    check("abort_busy", int'(busy_o), 0);
    check("abort_tx", int'(ir_tx_o), 0);
    repeat (400) @(negedge clk);
    check("abort_no_done", done_total - d0, 0);
    capture(1'b1, 1'b0, 32'hE51A00FF);
    check("after_abort_len", cap_len, 772);
    check("after_abort_done", cap_done, 1);

    // randomized traffic, back-to-back requests, spurious requests, resets
    for (int k = 0; k < 20; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      mode = $urandom_range(0, 2);
      d    = $urandom;
      req(mode != 1, mode != 0, d);
      act = $urandom_range(0, 5);
      if (act == 0) begin
        repeat ($urandom_range(1, 700)) @(posedge clk);
        #2;
        do_reset();
      end else if (act == 1) begin
        repeat ($urandom_range(1, 300)) @(posedge clk);
        #2;
        req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      end
      wait_idle();
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ir_transmit.md
IR_TRANSMIT -- requirements
Module: ir_transmit

Interface
REQ-001 SHALL have parameter UNIT_CLKS, default 28125, giving clocks per 562.5 us NEC time unit at 50 MHz.
REQ-002 SHALL have parameter CARRIER_CLKS, default 1316, giving clocks per 38 kHz carrier period.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to send a full frame.
REQ-006 SHALL have port repeat  input  1  request to send a NEC repeat frame.
REQ-007 SHALL have port data  input  32  frame payload: [15:0] custom code, [23:16] key code, [31:24] inverted key; same layout the receiver delivers.
REQ-008 SHALL have port busy  output  1  frame in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port ir_tx  output  1  LED drive; 1 = emitter on.

Function
REQ-011 SHALL implement states IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-012 SHALL accept a request only in IDLE; start with repeat in the same cycle: start wins; requests while busy are ignored, not queued.
REQ-013 SHALL latch data on the accepting cycle; later data changes do not affect the frame.
REQ-014 SHALL enter LEAD_MARK and raise busy on the cycle after acceptance (latency 1).
REQ-015 SHALL hold each state for an exact count of units: LEAD_MARK 16, LEAD_SPACE 8, REP_SPACE 4, BIT_MARK 1, BIT_SPACE 1 for a 0 bit or 3 for a 1 bit, STOP_MARK 1, GAP 72.
REQ-016 Full frame path: LEAD_MARK -> LEAD_SPACE -> 32 x (BIT_MARK -> BIT_SPACE) -> STOP_MARK -> GAP -> IDLE.
REQ-017 Repeat frame path: LEAD_MARK -> REP_SPACE -> STOP_MARK -> GAP -> IDLE.
REQ-018 SHALL transmit data LSB first, bit 0 through bit 31; 6-bit bit index, terminates after index 31.
REQ-019 SHALL drive ir_tx active only in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 in every other state.
REQ-020 On the last cycle of GAP: pulse done for one cycle, drop busy, return to IDLE in the same cycle; a request in the following cycle is accepted.

Reset
REQ-021 rst SHALL force IDLE, busy=0, done=0, ir_tx=0, and clear all counters on the next edge.
REQ-022 Reset mid-frame SHALL abort with no done pulse; reset has priority over start and repeat.

Configuration
REQ-023 With IR_CARRIER_EN defined: mark states drive ir_tx with a 38 kHz carrier, high for the first CARRIER_CLKS/2 cycles of each period.
REQ-024 The carrier phase counter SHALL restart at the first cycle of each mark, so every mark begins high.
REQ-025 Without IR_CARRIER_EN: ir_tx is baseband, constant 1 during marks; no carrier logic is built.

Structure
REQ-026 Shared package ir_pkg SHALL hold the state enum and the unit-count constants (16, 8, 4, 3, 1, 72) plus the default UNIT_CLKS and CARRIER_CLKS.
REQ-027 Sub-module ir_unit_tick SHALL be a restartable prescaler that pulses every UNIT_CLKS cycles; the FSM restarts it on each state entry.
REQ-028 Per-state unit counter SHALL be 7 bits wide; prescaler counter SHALL be wide enough for UNIT_CLKS-1.

Verification (UNIT_CLKS=4, CARRIER_CLKS=4)
REQ-029 Reset, then start with data=32'hE51A00FF -> busy rises 1 cycle later; ir_tx high 64 cycles, low 32; bits 0-7 each mark 4 / space 12; bits 8-15 each mark 4 / space 4; done exactly once after gap of 288 cycles.
REQ-030 repeat only -> mark 64, space 16, mark 4, gap 288, then done; total busy time 372 cycles.
REQ-031 start and repeat in the same cycle -> full frame sent; start pulsed during a frame -> ignored, exactly one done.
REQ-032 rst asserted during bit 10 -> next cycle ir_tx=0, busy=0; no done pulse; a fresh start afterwards produces a correct full frame.
REQ-033 IR_CARRIER_EN defined -> each mark toggles 2 high / 2 low starting high; spaces stay 0. Payload round-trip through the IR receiver reports key 8'h1A at [23:16].
